thread_scheduler: RTL
=====================

THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter: QUANTUM, default 16, range 2..255; max consecutive unstalled RUN cycles one thread holds the core while the other is runnable.
REQ-002 clk  in  1  core clock; all state changes on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 thread_en  in  2  per-thread enable mask; bit t set = thread t may be scheduled.
REQ-005 i_block_valid, i_block_tid  in  1,1  one-cycle event: thread i_block_tid blocked (e.g. cache miss).
REQ-006 i_unblock_valid, i_unblock_tid  in  1,1  one-cycle event: thread i_unblock_tid's blocking condition resolved.
REQ-007 i_stall  in  1  pipeline hazard hold; defers quantum-driven switches.
REQ-008 o_thread_id  out  1  thread selected for fetch/decode; drives the register file thread_id.
REQ-009 o_thread_valid  out  1  high only in RUN; pipeline issues only when high.
REQ-010 o_switch  out  1  one-cycle flush pulse; younger in-flight instructions are squashed.
REQ-011 o_blocked  out  2  registered per-thread blocked flags.

Function
REQ-012 FSM states IDLE, SWITCH, RUN; all outputs registered, no combinational input-to-output path.
REQ-013 runnable[t] = thread_en[t] & ~o_blocked[t].
REQ-014 Blocked flags: block event sets bit, unblock event clears bit; same tid same cycle -> bit cleared; events on different tids both apply.
REQ-015 IDLE: o_thread_valid=0, o_switch=0; if any thread runnable -> SWITCH next edge, o_thread_id = thread after last_tid if runnable, else the other thread; otherwise stay IDLE.
REQ-016 SWITCH: lasts exactly one cycle, o_switch=1, o_thread_valid=0, o_thread_id already holds new thread; -> RUN; quantum counter cleared to 0.
REQ-017 RUN: o_thread_valid=1; last_tid updated to o_thread_id each RUN cycle.
REQ-018 RUN exit on block event for current thread or thread_en[current]=0: if other thread runnable -> SWITCH to it, else -> IDLE; taken regardless of i_stall.
REQ-019 RUN quantum: counter increments on RUN cycles with i_stall=0, saturating at QUANTUM-1.
REQ-020 Counter at QUANTUM-1, i_stall=0, other thread runnable -> SWITCH to other thread; no switch if other thread not runnable (counter stays saturated).
REQ-021 Quantum switch with i_stall=1: deferred until first cycle with i_stall=0.
REQ-022 Block event for the non-running thread in RUN: flag set only, no state change.
REQ-023 Unblock event in the same cycle as a scheduling decision is not visible to that decision (uses registered flags).
REQ-024 thread_en=2'b00: always IDLE after at most one cycle; enable change mid-SWITCH takes effect in RUN next cycle.

Reset
REQ-025 On rst=1 at clock edge: state IDLE, o_thread_id=0, last_tid=1, o_thread_valid=0, o_switch=0, o_blocked=2'b00, counter=0; rst overrides all events in that cycle.
REQ-026 Reset mid-RUN or mid-SWITCH: outputs take reset values on the next edge; first RUN after reset release selects thread 0 if runnable.

Configuration
REQ-027 Macro THREAD_QUANTUM_EN: defined -> REQ-019..021 active (time-sliced preemption).
REQ-028 Undefined -> no quantum counter; RUN exits only per REQ-018 (switch-on-event only); all other behaviour identical.

Verification
REQ-029 Reset, thread_en=2'b11, no events -> cycle1 SWITCH (o_switch=1, tid 0), cycle2 RUN tid 0 valid=1.
REQ-030 RUN tid0, block tid0 -> next cycle o_switch=1 tid1, o_blocked=01; then RUN tid1.
REQ-031 Both threads blocked in turn -> IDLE, valid=0; unblock tid0 -> IDLE one more cycle, then SWITCH tid0, RUN.
REQ-032 THREAD_QUANTUM_EN, QUANTUM=4, both runnable, no stall -> tid alternates: 4 RUN cycles, 1 SWITCH, repeat.
REQ-033 THREAD_QUANTUM_EN, QUANTUM=4, i_stall=1 from RUN cycle 2 for 5 cycles -> no switch until stall drops, switch after 4th unstalled RUN cycle.
REQ-034 Block and unblock tid1 same cycle while running tid0 -> o_blocked stays 00; rst asserted during SWITCH -> IDLE, tid0, all outputs reset.

Source files
------------

// File: rtl/thread_scheduler.sv
// Two-thread fine-grained scheduler: IDLE -> SWITCH (flush pulse) -> RUN, switch on block/disable.
// Define THREAD_QUANTUM_EN to add time-sliced preemption after QUANTUM unstalled RUN cycles.
module thread_scheduler #(
  parameter int QUANTUM = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] thread_en,
  input  logic       i_block_valid,
  input  logic       i_block_tid,
  input  logic       i_unblock_valid,
  input  logic       i_unblock_tid,
  input  logic       i_stall,
  output logic       o_thread_id,
  output logic       o_thread_valid,
  output logic       o_switch,
  output logic [1:0] o_blocked
);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  state_t     state_q, state_d;
  logic       tid_q, tid_d;
  logic       last_q, last_d;
  logic [1:0] blocked_q, blocked_d;
  logic       valid_q, switch_q;
  logic [1:0] runnable;
  logic       cur_out;

`ifdef THREAD_QUANTUM_EN
  localparam int CW = $clog2(QUANTUM);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_stall;
  assign unused_stall = i_stall;
`endif

  // Decisions use the registered flags, so a same-cycle unblock is not yet visible.
  assign runnable = thread_en & ~blocked_q;

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      blocked_d[t] = blocked_q[t];
      if (i_block_valid && (i_block_tid == 1'(t)))     blocked_d[t] = 1'b1;
      if (i_unblock_valid && (i_unblock_tid == 1'(t))) blocked_d[t] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    tid_d   = tid_q;
    last_d  = last_q;
    cur_out = 1'b0;
`ifdef THREAD_QUANTUM_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|runnable) begin
          state_d = SWITCH;
          tid_d   = runnable[~last_q] ? ~last_q : last_q;
        end
      end
      SWITCH: begin
        state_d = RUN;
`ifdef THREAD_QUANTUM_EN
        cnt_d   = '0;
`endif
      end
      RUN: begin
        last_d  = tid_q;
        // A thread blocked while its SWITCH was in flight is also evicted here.
        cur_out = (i_block_valid && (i_block_tid == tid_q)) || !runnable[tid_q];
        if (cur_out) begin
          if (runnable[~tid_q]) begin
            state_d = SWITCH;
            tid_d   = ~tid_q;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef THREAD_QUANTUM_EN
        else if (!i_stall) begin
          if (cnt_q == CW'(QUANTUM - 1)) begin
            if (runnable[~tid_q]) begin
              state_d = SWITCH;
              tid_d   = ~tid_q;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tid_q     <= 1'b0;
      last_q    <= 1'b1;
      blocked_q <= 2'b00;
      valid_q   <= 1'b0;
      switch_q  <= 1'b0;
`ifdef THREAD_QUANTUM_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      tid_q     <= tid_d;
      last_q    <= last_d;
      blocked_q <= blocked_d;
      valid_q   <= (state_d == RUN);
      switch_q  <= (state_d == SWITCH);
`ifdef THREAD_QUANTUM_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign o_thread_id    = tid_q;
  assign o_thread_valid = valid_q;
  assign o_switch       = switch_q;
  assign o_blocked      = blocked_q;

endmodule
